// File: rtl/mux2_clk.sv
// Purpose : clocked 4-phase bundled-data 2-way select; a control token picks
//           channel 0 or 1 and forwards that channel's data to the output.
// Latency : r_o rises one edge after the IDLE->WAIT_IN edge (edge k+1 when
//           rctl_i and the selected request are both high at edge k).
// Backpressure: the unselected input is never acknowledged and simply stalls;
//           the output holds r_o until a_o arrives, and the control and
//           selected acks hold until a_o, the selected request and rctl_i
//           have all returned to zero.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rctl_i/dctl_i/actl_i  : control channel (req / select bit / ack)
//   r0_i/a0_i/d0_i        : input channel 0 (req / ack / data)
//   r1_i/a1_i/d1_i        : input channel 1 (req / ack / data)
//   r_o/a_o/d_o           : output channel (req / ack / registered data)
module mux2_clk #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rctl_i,
  input  logic         dctl_i,
  output logic         actl_i,
  input  logic         r0_i,
  output logic         a0_i,
  input  logic [N-1:0] d0_i,
  input  logic         r1_i,
  output logic         a1_i,
  input  logic [N-1:0] d1_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_IN = 2'd1;
  localparam logic [1:0] WAIT_AO = 2'd2;
  localparam logic [1:0] RTZ     = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         sel_q,   sel_d;
  logic         r_o_q,   r_o_d;
  logic         a0_q,    a0_d;
  logic         a1_q,    a1_d;
  logic         actl_q,  actl_d;
  logic [N-1:0] d_q,     d_d;

  // Request of the channel chosen by the latched token; the other request
  // is deliberately never looked at.
  logic req_sel;
  assign req_sel = sel_q ? r1_i : r0_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    r_o_d   = r_o_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    actl_d  = actl_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        // Select bit is latched only here; later changes of dctl_i are ignored.
        if (rctl_i) begin
          sel_d   = dctl_i;
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (req_sel) begin
          d_d     = sel_q ? d1_i : d0_i;
          r_o_d   = 1'b1;
          state_d = WAIT_AO;
        end
      end
      WAIT_AO: begin
        // Control and selected input are acknowledged on the same edge.
        if (a_o) begin
          r_o_d   = 1'b0;
          actl_d  = 1'b1;
          if (sel_q) a1_d = 1'b1;
          else       a0_d = 1'b1;
          state_d = RTZ;
        end
      end
      RTZ: begin
        // All three return-to-zero conditions may arrive in any order.
        if (!a_o && !req_sel && !rctl_i) begin
          a0_d    = 1'b0;
          a1_d    = 1'b0;
          actl_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      r_o_q   <= 1'b0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      actl_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      r_o_q   <= r_o_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      actl_q  <= actl_d;
      d_q     <= d_d;
    end
  end

  assign r_o    = r_o_q;
  assign a0_i   = a0_q;
  assign a1_i   = a1_q;
  assign actl_i = actl_q;
  assign d_o    = d_q;

endmodule

// File: tb/tb_mux2_clk.sv
module tb_mux2_clk;

  logic       clk = 1'b0;
  logic       rst;
  logic       rctl_i, dctl_i, actl_i;
  logic       r0_i, a0_i, r1_i, a1_i;
  logic [7:0] d0_i, d1_i, d_o;
  logic       r_o, a_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic r_prev = 1'b0;

  mux2_clk #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .rctl_i(rctl_i), .dctl_i(dctl_i), .actl_i(actl_i),
    .r0_i(r0_i), .a0_i(a0_i), .d0_i(d0_i),
    .r1_i(r1_i), .a1_i(a1_i), .d1_i(d1_i),
    .r_o(r_o), .a_o(a_o), .d_o(d_o)
  );

  always #5 clk = ~clk;

  // Count rising edges of r_o, sampled away from the active edge.
  always @(negedge clk) begin
    if (r_o && !r_prev) pulses++;
    r_prev = r_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a token for channel s with data dat (other request low),
  // and check r_o rises two edges later with the right data.
  task automatic req_phase(input logic s, input logic [7:0] dat, input string tag);
    rctl_i = 1'b1; dctl_i = s;
    if (s) begin r1_i = 1'b1; d1_i = dat; r0_i = 1'b0; end
    else   begin r0_i = 1'b1; d0_i = dat; r1_i = 1'b0; end
    tick();
    chk({tag, "_ro_early"}, {15'd0, r_o}, 16'd0);
    tick();
    chk({tag, "_ro"}, {15'd0, r_o}, 16'd1);
    chk({tag, "_do"}, {8'd0, d_o}, {8'd0, dat});
  endtask

  // Acknowledge the output; selected ack and actl must rise together.
  task automatic ack_phase(input logic s, input string tag);
    a_o = 1'b1;
    tick();
    chk({tag, "_ack"}, {12'd0, r_o, actl_i, a0_i, a1_i}, {12'd0, 1'b0, 1'b1, ~s, s});
  endtask

  task automatic drop(input int idx);
    case (idx)
      0: a_o = 1'b0;
      1: begin r0_i = 1'b0; r1_i = 1'b0; end
      default: rctl_i = 1'b0;
    endcase
  endtask

  int perm [6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

  initial begin
    int p0;
    rst = 1'b1;
    // Reset with random inputs for 3 cycles
    for (int i = 0; i < 3; i++) begin
      rctl_i = 1'($urandom_range(0, 1)); dctl_i = 1'($urandom_range(0, 1));
      r0_i = 1'($urandom_range(0, 1));   r1_i = 1'($urandom_range(0, 1));
      a_o = 1'($urandom_range(0, 1));
      d0_i = 8'($urandom_range(0, 255)); d1_i = 8'($urandom_range(0, 255));
      tick();
      chk("reset_ctl", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);
      chk("reset_do", {8'd0, d_o}, 16'd0);
    end
    rctl_i = 0; dctl_i = 0; r0_i = 0; r1_i = 0; a_o = 0; d0_i = 0; d1_i = 0;
    rst = 1'b0;
    tick(); tick();
    chk("idle_ctl", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);

    // Select 0 while both requests are high
    rctl_i = 1; dctl_i = 0; r0_i = 1; d0_i = 8'hA5; r1_i = 1; d1_i = 8'h3C;
    tick();
    chk("s0_ro_early", {15'd0, r_o}, 16'd0);
    tick();
    chk("s0_ro", {15'd0, r_o}, 16'd1);
    chk("s0_do", {8'd0, d_o}, 16'h00A5);
    chk("s0_a1", {15'd0, a1_i}, 16'd0);
    a_o = 1;
    tick();
    chk("s0_ack", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'b0110);
    tick();
    chk("s0_hold", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'b0110);
    rctl_i = 0; r0_i = 0; a_o = 0;
    tick();
    chk("s0_rtz", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);
    r1_i = 0;
    tick();
    chk("s0_idle", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);
    chk("s0_do_hold", {8'd0, d_o}, 16'h00A5);

    // Select 1 with late data; dctl_i change after the token is ignored
    rctl_i = 1; dctl_i = 1;
    tick();
    dctl_i = 0; r0_i = 1; d0_i = 8'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("late_wait", {15'd0, r_o}, 16'd0);
    end
    r1_i = 1; d1_i = 8'h5A;
    tick();
    chk("late_ro", {15'd0, r_o}, 16'd1);
    chk("late_do", {8'd0, d_o}, 16'h005A);
    ack_phase(1'b1, "late");
    rctl_i = 0; r1_i = 0; r0_i = 0; a_o = 0;
    tick();
    chk("late_rtz", {12'd0, actl_i, a0_i, a1_i}, 16'd0);

    // RTZ ordering: all 6 permutations, one drop per cycle
    for (int p = 0; p < 6; p++) begin
      req_phase(p[0], 8'(8'h10 + p), "perm");
      ack_phase(p[0], "perm");
      for (int k = 0; k < 3; k++) begin
        drop(perm[p][k]);
        tick();
        if (k < 2)
          chk("perm_held", {13'd0, actl_i, a0_i, a1_i}, {13'd0, 1'b1, ~p[0], p[0]});
        else
          chk("perm_fall", {13'd0, actl_i, a0_i, a1_i}, 16'd0);
      end
    end

    // Back-to-back alternating tokens, immediate environment
    p0 = pulses;
    for (int t = 0; t < 4; t++) begin
      req_phase(t[0], 8'(t + 1), "b2b");
      ack_phase(t[0], "b2b");
      rctl_i = 0; r0_i = 0; r1_i = 0; a_o = 0;
      tick();
      chk("b2b_rtz", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);
    end
    tick();
    chk("b2b_pulses", 16'(pulses - p0), 16'd4);
    chk("b2b_last", {8'd0, d_o}, 16'h0004);

    // Reset in WAIT_AO, then a clean transaction
    req_phase(1'b0, 8'hC3, "mid");
    rst = 1;
    tick();
    chk("mid_rst", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);
    chk("mid_rst_do", {8'd0, d_o}, 16'd0);
    rst = 0; rctl_i = 0; r0_i = 0; r1_i = 0; a_o = 0;
    tick();
    req_phase(1'b1, 8'h96, "post");
    ack_phase(1'b1, "post");
    rctl_i = 0; r1_i = 0; a_o = 0;
    tick();
    chk("post_rtz", {12'd0, r_o, actl_i, a0_i, a1_i}, 16'd0);
    chk("post_do", {8'd0, d_o}, 16'h0096);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
